// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants and the pure instruction decoder for the ID stage.
// The decoder reports only which registers an instruction reads; operand values are resolved in the top.
package id_stage_pipe_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'b000000,
    OP_ADDIU   = 6'b001001,
    OP_ANDI    = 6'b001100,
    OP_ORI     = 6'b001101,
    OP_XORI    = 6'b001110,
    OP_LUI     = 6'b001111
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'b000000,
    FN_SRL  = 6'b000010,
    FN_SRA  = 6'b000011,
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110,
    FN_NOR  = 6'b100111
  } funct_e;

  typedef enum logic [7:0] {
    ALU_NOP  = 8'b0000_0000,
    ALU_SRL  = 8'b0000_0010,
    ALU_SRA  = 8'b0000_0011,
    ALU_ADDU = 8'b0010_0001,
    ALU_SUBU = 8'b0010_0011,
    ALU_AND  = 8'b0010_0100,
    ALU_OR   = 8'b0010_0101,
    ALU_XOR  = 8'b0010_0110,
    ALU_NOR  = 8'b0010_0111,
    ALU_LUI  = 8'b0101_1100,
    ALU_SLL  = 8'b0111_1100
  } aluop_e;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_SHIFT = 3'b010,
    SEL_ARITH = 3'b100
  } alusel_e;

  localparam logic [4:0]  NOP_REG_ADDR = '0;
  localparam logic [31:0] ZERO_WORD    = '0;

  typedef struct packed {
    aluop_e      aluop;
    alusel_e     alusel;
    logic        re1;       // rs is read
    logic        re2;       // rt is read
    logic        op1_rt;    // shifts: operand 1 comes from rt
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] imm;       // already extended to 32 bits
    logic        imm_sext;  // widen imm by sign rather than zero
    logic        invalid;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t        d;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic        ity;
    logic        rty;
    logic        sht;
    op    = inst[31:26];
    fn    = inst[5:0];
    rt    = inst[20:16];
    rd    = inst[15:11];
    shamt = inst[10:6];
    imm16 = inst[15:0];
    ity   = 1'b0;
    rty   = 1'b0;
    sht   = 1'b0;
    d.aluop    = ALU_NOP;
    d.alusel   = SEL_NOP;
    d.re1      = 1'b0;
    d.re2      = 1'b0;
    d.op1_rt   = 1'b0;
    d.wreg     = 1'b0;
    d.wd       = NOP_REG_ADDR;
    d.imm      = ZERO_WORD;
    d.imm_sext = 1'b0;
    d.invalid  = 1'b1;
    if (inst == ZERO_WORD) begin
      d.invalid = 1'b0;
    end else begin
      case (op)
        OP_ORI:   begin ity = 1'b1; d.aluop = ALU_OR;  d.alusel = SEL_LOGIC; d.imm = {16'h0, imm16}; end
        OP_ANDI:  begin ity = 1'b1; d.aluop = ALU_AND; d.alusel = SEL_LOGIC; d.imm = {16'h0, imm16}; end
        OP_XORI:  begin ity = 1'b1; d.aluop = ALU_XOR; d.alusel = SEL_LOGIC; d.imm = {16'h0, imm16}; end
        OP_LUI:   begin ity = 1'b1; d.aluop = ALU_LUI; d.alusel = SEL_LOGIC; d.imm = {imm16, 16'h0}; end
        OP_ADDIU: begin
          ity = 1'b1; d.aluop = ALU_ADDU; d.alusel = SEL_ARITH;
          d.imm = {{16{imm16[15]}}, imm16}; d.imm_sext = 1'b1;
        end
        OP_SPECIAL: begin
          case (fn)
            FN_AND:  begin rty = 1'b1; d.aluop = ALU_AND;  d.alusel = SEL_LOGIC; end
            FN_OR:   begin rty = 1'b1; d.aluop = ALU_OR;   d.alusel = SEL_LOGIC; end
            FN_XOR:  begin rty = 1'b1; d.aluop = ALU_XOR;  d.alusel = SEL_LOGIC; end
            FN_NOR:  begin rty = 1'b1; d.aluop = ALU_NOR;  d.alusel = SEL_LOGIC; end
            FN_ADDU: begin rty = 1'b1; d.aluop = ALU_ADDU; d.alusel = SEL_ARITH; end
            FN_SUBU: begin rty = 1'b1; d.aluop = ALU_SUBU; d.alusel = SEL_ARITH; end
            FN_SLL:  begin sht = 1'b1; d.aluop = ALU_SLL;  d.alusel = SEL_SHIFT; end
            FN_SRL:  begin sht = 1'b1; d.aluop = ALU_SRL;  d.alusel = SEL_SHIFT; end
            FN_SRA:  begin sht = 1'b1; d.aluop = ALU_SRA;  d.alusel = SEL_SHIFT; end
            default: ;
          endcase
        end
        default: ;
      endcase
      if (ity) begin
        d.re1 = 1'b1; d.wreg = 1'b1; d.wd = rt; d.invalid = 1'b0;
      end
      if (rty) begin
        d.re1 = 1'b1; d.re2 = 1'b1; d.wreg = 1'b1; d.wd = rd; d.invalid = 1'b0;
      end
      if (sht) begin
        d.re2 = 1'b1; d.op1_rt = 1'b1; d.wreg = 1'b1; d.wd = rd;
        d.imm = {27'h0, shamt}; d.invalid = 1'b0;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// Operand source select for one register read port: $0, EX forward, MEM forward, regfile.
module id_fwd_mux
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = rf_data;
    if (addr == '0)
      data = '0;
    else if (ex_wreg && (ex_wd == addr))
      data = ex_wdata;
    else if (mem_wreg && (mem_wd == addr))
      data = mem_wdata;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS-style decode stage: combinational decode + forwarding, load-use stall,
// and a valid/ready ID/EX output register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [31:0]         inst_i,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic                inst_invalid_o
);

  dec_t              dec;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              stall;
  logic              take;

  assign dec         = decode(inst_i);
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .addr      (reg1_addr_o),
    .rf_data   (reg1_data_i),
    .ex_wreg   (ex_wreg_i),
    .ex_wd     (ex_wd_i),
    .ex_wdata  (ex_wdata_i),
    .mem_wreg  (mem_wreg_i),
    .mem_wd    (mem_wd_i),
    .mem_wdata (mem_wdata_i),
    .data      (fwd1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .addr      (reg2_addr_o),
    .rf_data   (reg2_data_i),
    .ex_wreg   (ex_wreg_i),
    .ex_wd     (ex_wd_i),
    .ex_wdata  (ex_wdata_i),
    .mem_wreg  (mem_wreg_i),
    .mem_wd    (mem_wd_i),
    .mem_wdata (mem_wdata_i),
    .data      (fwd2)
  );

  always_comb begin
    imm_ext = dec.imm_sext ? DATA_W'(signed'(dec.imm)) : DATA_W'(dec.imm);
    op1     = '0;
    op2     = imm_ext;
    if (dec.op1_rt)
      op1 = fwd2;
    else if (dec.re1)
      op1 = fwd1;
    if (dec.re2 && !dec.op1_rt)
      op2 = fwd2;
  end

  // Only a register the instruction actually reads can cause a load-use stall.
  always_comb begin
    stall = 1'b0;
    if (ex_is_load_i && ex_wreg_i && (ex_wd_i != '0))
      stall = (dec.re1 && (ex_wd_i == reg1_addr_o)) ||
              (dec.re2 && (ex_wd_i == reg2_addr_o));
  end

  assign in_ready = !flush && !stall && (!out_valid || out_ready);
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= ALUOP_W'(ALU_NOP);
      alusel_o       <= ALUSEL_W'(SEL_NOP);
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid      <= 1'b1;
      pc_o           <= pc_i;
      aluop_o        <= ALUOP_W'(dec.aluop);
      alusel_o       <= ALUSEL_W'(dec.alusel);
      reg1_o         <= op1;
      reg2_o         <= op2;
      wd_o           <= REG_AW'(dec.wd);
      wreg_o         <= dec.wreg;
      inst_invalid_o <= dec.invalid;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode/forwarding vector table plus
// hand-written stall, backpressure, flush and reset sequences.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pc_i, inst_i, pc_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o, ex_wd_i, mem_wd_i, wd_o;
  logic [31:0] reg1_data_i, reg2_data_i, ex_wdata_i, mem_wdata_i, reg1_o, reg2_o;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i, wreg_o, inst_invalid_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;

  logic [31:0] rf [32];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  id_stage_pipe #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .ALUOP_W(8), .ALUSEL_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o), .aluop_o(aluop_o),
    .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .inst_invalid_o(inst_invalid_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic        exw;  logic [4:0] exd; logic [31:0] exdat; logic exld;
    logic        mw;   logic [4:0] md;  logic [31:0] mdat;
    logic [7:0]  aluop; logic [2:0] sel;
    logic [31:0] r1, r2;
    logic [4:0]  wd;   logic wreg; logic inv;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc);
    inst_i = v.inst; pc_i = pc;
    ex_wreg_i = v.exw; ex_wd_i = v.exd; ex_wdata_i = v.exdat; ex_is_load_i = v.exld;
    mem_wreg_i = v.mw; mem_wd_i = v.md; mem_wdata_i = v.mdat;
  endtask

  task automatic clear_fwd();
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
  endtask

  task automatic chk_out(input string tag, input vec_t v, input logic [31:0] pc);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".pc"},        pc_o, pc);
    chk({tag, ".aluop"},     32'(aluop_o), 32'(v.aluop));
    chk({tag, ".alusel"},    32'(alusel_o), 32'(v.sel));
    chk({tag, ".reg1"},      reg1_o, v.r1);
    chk({tag, ".reg2"},      reg2_o, v.r2);
    chk({tag, ".wd"},        32'(wd_o), 32'(v.wd));
    chk({tag, ".wreg"},      32'(wreg_o), 32'(v.wreg));
    chk({tag, ".invalid"},   32'(inst_invalid_o), 32'(v.inv));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".pc"},        pc_o, 32'd0);
    chk({tag, ".aluop"},     32'(aluop_o), 32'd0);
    chk({tag, ".alusel"},    32'(alusel_o), 32'd0);
    chk({tag, ".reg1"},      reg1_o, 32'd0);
    chk({tag, ".reg2"},      reg2_o, 32'd0);
    chk({tag, ".wd"},        32'(wd_o), 32'd0);
    chk({tag, ".wreg"},      32'(wreg_o), 32'd0);
    chk({tag, ".invalid"},   32'(inst_invalid_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 | 32'(i);
    rf[0] = 32'hBAD0_0000;  // must never reach an operand
    rf[1] = 32'h1200_0000;
    rf[2] = 32'h0000_0009;
    rf[3] = 32'hF0F0_0003;
    rf[4] = 32'h0000_0044;
    rf[5] = 32'h8000_0005;

    //          inst          exw   exd    exdata        ld    mw    md     mdata         aluop  sel     r1            r2            wd     wreg  inv
    vecs[0]  = '{32'h342100FF, 1'b1, 5'd9,  32'h0000_0099, 1'b1, 1'b0, 5'd0,  32'h0,        8'h25, 3'd1, 32'h1200_0000, 32'h0000_00FF, 5'd1,  1'b1, 1'b0};
    vecs[1]  = '{32'h00221821, 1'b1, 5'd1,  32'hAAAA_0000, 1'b0, 1'b1, 5'd2,  32'h7,        8'h21, 3'd4, 32'hAAAA_0000, 32'h0000_0007, 5'd3,  1'b1, 1'b0};
    vecs[2]  = '{32'h00221821, 1'b1, 5'd1,  32'hAAAA_0000, 1'b0, 1'b1, 5'd1,  32'h5555,     8'h21, 3'd4, 32'hAAAA_0000, 32'h0000_0009, 5'd3,  1'b1, 1'b0};
    vecs[3]  = '{32'h00221821, 1'b0, 5'd1,  32'hAAAA_0000, 1'b0, 1'b1, 5'd1,  32'h5555,     8'h21, 3'd4, 32'h0000_5555, 32'h0000_0009, 5'd3,  1'b1, 1'b0};
    vecs[4]  = '{32'h30658001, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h24, 3'd1, 32'hF0F0_0003, 32'h0000_8001, 5'd5,  1'b1, 1'b0};
    vecs[5]  = '{32'h3886FFFF, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h26, 3'd1, 32'h0000_0044, 32'h0000_FFFF, 5'd6,  1'b1, 1'b0};
    vecs[6]  = '{32'h3C071234, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h5C, 3'd1, 32'h0000_0000, 32'h1234_0000, 5'd7,  1'b1, 1'b0};
    vecs[7]  = '{32'h24A8FFFE, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h21, 3'd4, 32'h8000_0005, 32'hFFFF_FFFE, 5'd8,  1'b1, 1'b0};
    vecs[8]  = '{32'h00854823, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h23, 3'd4, 32'h0000_0044, 32'h8000_0005, 5'd9,  1'b1, 1'b0};
    vecs[9]  = '{32'h00235027, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd3,  32'h1111,     8'h27, 3'd1, 32'h1200_0000, 32'h0000_1111, 5'd10, 1'b1, 1'b0};
    vecs[10] = '{32'h000458C0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h7C, 3'd2, 32'h0000_0044, 32'h0000_0003, 5'd11, 1'b1, 1'b0};
    vecs[11] = '{32'h000567C3, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h03, 3'd2, 32'h8000_0005, 32'h0000_001F, 5'd12, 1'b1, 1'b0};
    vecs[12] = '{32'h00026842, 1'b1, 5'd2,  32'h0000_CAFE, 1'b0, 1'b0, 5'd0,  32'h0,        8'h02, 3'd2, 32'h0000_CAFE, 32'h0000_0001, 5'd13, 1'b1, 1'b0};
    vecs[13] = '{32'hFC000000, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h00, 3'd0, 32'h0,         32'h0,         5'd0,  1'b0, 1'b1};
    vecs[14] = '{32'h00000000, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h00, 3'd0, 32'h0,         32'h0,         5'd0,  1'b0, 1'b0};
    vecs[15] = '{32'h00017025, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0,  32'hEEEE_EEEE, 8'h25, 3'd1, 32'h0,         32'h1200_0000, 5'd14, 1'b1, 1'b0};
    vecs[16] = '{32'h00647824, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h24, 3'd1, 32'hF0F0_0003, 32'h0000_0044, 5'd15, 1'b1, 1'b0};
    vecs[17] = '{32'h00A28026, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0,        8'h26, 3'd1, 32'h8000_0005, 32'h0000_0009, 5'd16, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst_i = '0; pc_i = '0;
    clear_fwd();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Back-to-back table rows: one instruction per cycle.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i], 32'h0040_0000 + 32'(i) * 4);
      in_valid = 1'b1;
      #1 chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vecs[i], 32'h0040_0000 + 32'(i) * 4);
    end

    in_valid = 1'b0;
    clear_fwd();
    @(negedge clk);
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Load-use stall on rs, then release with EX forwarding.
    inst_i = 32'h00854823; pc_i = 32'h0000_1000; in_valid = 1'b1;
    ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 32'h0000_4444; ex_is_load_i = 1'b1;
    #1 chk("lu_rs.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lu_rs.bubble", 32'(out_valid), 32'd0);
    ex_wd_i = 5'd5;
    #1 chk("lu_rt.in_ready", 32'(in_ready), 32'd0);
    ex_wd_i = 5'd4; ex_is_load_i = 1'b0;
    #1 chk("lu_release.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("lu_release.out_valid", 32'(out_valid), 32'd1);
    chk("lu_release.reg1", reg1_o, 32'h0000_4444);
    chk("lu_release.reg2", reg2_o, 32'h8000_0005);
    chk("lu_release.aluop", 32'(aluop_o), 32'h23);

    // Loads that must not stall: dest $0, or a field that is not read.
    in_valid = 1'b0; ex_is_load_i = 1'b1;
    inst_i = 32'h00017025; ex_wd_i = 5'd0;
    #1 chk("lu_zero.in_ready", 32'(in_ready), 32'd1);
    inst_i = 32'h3C071234; ex_wd_i = 5'd7;
    #1 chk("lu_notread.in_ready", 32'(in_ready), 32'd1);
    inst_i = 32'h000458C0; ex_wd_i = 5'd4;
    #1 chk("lu_shift_rt.in_ready", 32'(in_ready), 32'd0);
    clear_fwd();
    @(negedge clk);

    // Backpressure: held entry must not pick up new forwarding data.
    drive(vecs[0], 32'h0000_2000);
    ex_is_load_i = 1'b0; ex_wd_i = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp.first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    drive(vecs[5], 32'h0000_2004);
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'h0000_0077;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h0000_0066;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
      @(negedge clk);
      chk_out($sformatf("bp%0d", k), vecs[0], 32'h0000_2000);
    end
    out_ready = 1'b1;
    #1 chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk_out("bp_release", vecs[5], 32'h0000_2004);

    // Flush while holding: dropped, concurrent input refused.
    out_ready = 1'b0;
    clear_fwd();
    drive(vecs[4], 32'h0000_3000);
    flush = 1'b1;
    #1 chk("flush.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk_out("post_flush", vecs[4], 32'h0000_3000);

    // Illegal instruction held, then reset (with flush) mid-hold.
    out_ready = 1'b1;
    drive(vecs[13], 32'h0000_4000);
    @(negedge clk);
    chk_out("illegal", vecs[13], 32'h0000_4000);
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_hold.invalid", 32'(inst_invalid_o), 32'd1);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised MIPS-style instruction decode stage with a registered ID/EX output. It decodes a small ALU instruction subset and reads the register file combinationally. It resolves operands with EX and MEM forwarding and detects load-use hazards. Sits between the IF/ID register and the execute stage, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, register and immediate width (must be ≥ 32).
- ADDR_W, 32, instruction address width.
- REG_AW, 5, register address width (matches instruction fields).
- ALUOP_W, 8, ALU operation code width.
- ALUSEL_W, 3, result-select code width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  drop current/held instruction.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- pc_i  in  ADDR_W  instruction PC.
- inst_i  in  32  instruction word.
- reg1_addr_o  out  REG_AW  regfile read port 1 address (inst[25:21]).
- reg2_addr_o  out  REG_AW  regfile read port 2 address (inst[20:16]).
- reg1_data_i  in  DATA_W  regfile read data 1 (combinational).
- reg2_data_i  in  DATA_W  regfile read data 2 (combinational).
- ex_wreg_i  in  1  EX-stage write enable.
- ex_wd_i  in  REG_AW  EX-stage write address.
- ex_wdata_i  in  DATA_W  EX-stage write data.
- ex_is_load_i  in  1  EX instruction is a load (data not yet available).
- mem_wreg_i  in  1  MEM-stage write enable.
- mem_wd_i  in  REG_AW  MEM-stage write address.
- mem_wdata_i  in  DATA_W  MEM-stage write data.
- out_valid  out  1  ID/EX register valid.
- out_ready  in  1  EX accepts.
- pc_o  out  ADDR_W  registered PC.
- aluop_o  out  ALUOP_W  registered ALU operation.
- alusel_o  out  ALUSEL_W  registered result select.
- reg1_o  out  DATA_W  registered operand 1.
- reg2_o  out  DATA_W  registered operand 2.
- wd_o  out  REG_AW  registered destination.
- wreg_o  out  1  registered write enable.
- inst_invalid_o  out  1  registered illegal-instruction flag.

Behaviour:
- Reset: rst, synchronous, active-high. On reset, all registered outputs are 0, including out_valid, wreg_o and inst_invalid_o; aluop_o/alusel_o are NOP codes.
- Decode is combinational. Register ports are driven from inst_i regardless of validity.
- I-type: ORI/ANDI/XORI zero-extend imm16; LUI gives imm16<<16; ADDIU sign-extends imm16.
  - Operand 1 = rs, operand 2 = immediate; destination rt.
- R-type (op=0), selected by funct: AND/OR/XOR/NOR/ADDU/SUBU read rs, rt; destination rd.
- R-type shifts SLL/SRL/SRA: operand 1 = rt, operand 2 = zero-extended shamt (inst[10:6]); only rt is read.
- Unknown opcode/funct: wreg=0, aluop=NOP, inst_invalid=1. The instruction still flows so EX can trap.
- All-zero instruction: NOP, wreg=0, inst_invalid=0.
- Operand source priority for each read register:
  - Register 0 always yields 0.
  - Else EX match (ex_wreg_i && ex_wd_i==addr) → ex_wdata_i.
  - Else MEM match → mem_wdata_i.
  - Else regfile data.
- Load-use stall: ex_is_load_i && ex_wreg_i && ex_wd_i≠0 && ex_wd_i equals a register actually read → stall=1.
- in_ready = !stall && (!out_valid || out_ready).
- Transfer in: in_valid && in_ready → the output register loads the decoded fields next edge, out_valid=1.
- Transfer out without refill: out_valid && out_ready && no input transfer → out_valid=0.
- Hold: while out_valid && !out_ready, all outputs are held stable; forwarding is not re-evaluated for the held entry.
- Stall with empty/drained output: a bubble is produced (out_valid=0). IF must hold inst_i.
- flush: the next edge gives out_valid=0; in_ready forced 0 that cycle; flush dominates load and hold.
- rst dominates flush.
- Latency: one cycle from accepted input to out_valid. Throughput: 1/cycle with no stalls.

Decomposition:
- Shared package/defines: opcode and funct constants, ALU op codes (NOP, OR, AND, XOR, NOR, ADDU, SUBU, SLL, SRL, SRA, LUI), ALU select codes (NOP, LOGIC, SHIFT, ARITH), NOP register address, ZeroWord.
- Sub-module id_fwd_mux (one instance per operand): register-0 check, EX/MEM priority select, regfile fallback.

Test Plan:
1. ORI: inst 0x3421_00FF, $1=0x1200_0000, out_ready=1 → next cycle out_valid=1, reg1_o=0x1200_0000, reg2_o=0x0000_00FF, wd_o=1, wreg_o=1, aluop=OR.
2. Forward priority: ADDU $3,$1,$2 with EX writing $1=0xAAAA_0000, MEM writing $1=0x5555 and $2=0x7, regfile $2=0x9 → reg1_o=0xAAAA_0000, reg2_o=0x7.
3. Load-use: ex_is_load_i=1, ex_wd_i=4, inst reads $4 → in_ready=0, next cycle out_valid=0. Drop ex_is_load_i → instruction accepted the following cycle.
4. Backpressure: out_ready=0 for 3 cycles after a valid output → outputs bit-stable, in_ready=0. Release → next instruction loads the same edge the held one leaves.
5. Flush while holding (out_valid=1, out_ready=0) → next cycle out_valid=0. Concurrent in_valid is not accepted.
6. Illegal op 0xFC00_0000 → out_valid=1, inst_invalid_o=1, wreg_o=0. Register 0 read with EX writing $0=0xFFFF_FFFF → operand 0. Assert rst mid-hold → all outputs 0 next edge.
